// File: rtl/music_box_pkg.sv
// Shared music-box definitions: sequencer state encoding, note-entry
// field widths and slice positions, and the reserved code values.
// Used by the playback sequencer and the note recorder.
package music_box_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int NOTE_W_DEF  = 4;
  localparam int DUR_W_DEF   = 6;
  localparam int ENTRY_W_DEF = NOTE_W_DEF + DUR_W_DEF;

  // Note entry layout: {note, dur}
  localparam int DUR_LSB  = 0;
  localparam int NOTE_LSB = DUR_W_DEF;

  localparam int NOTE_REST = 0;  // note code for silence
  localparam int DUR_END   = 0;  // duration value marking end of song

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/note_playback_sequencer_if.sv
// Note memory read bus.
//   mem_addr : read address, driven by the sequencer (master)
//   mem_data : {note, dur} entry, valid one cycle after mem_addr changes
interface note_playback_sequencer_if
  import music_box_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
);

  logic [ADDR_W-1:0]       mem_addr;
  logic [NOTE_W+DUR_W-1:0] mem_data;

  modport master (output mem_addr, input  mem_data);
  modport slave  (input  mem_addr, output mem_data);

endinterface

// File: rtl/note_duration_counter.sv
// Per-note duration down-counter.
//   clock, reset : clock and async active-low reset
//   load         : load load_val (takes priority over counting)
//   load_val     : note duration in ticks
//   tick, en     : count one tick when both high
//   last_tick    : the tick that finishes the current note
module note_duration_counter
  import music_box_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             tick,
  input  logic             en,
  output logic             last_tick
);

  logic [DUR_W-1:0] count;

  assign last_tick = (count == DUR_W'(1)) && tick && en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && en && (count != '0)) begin
      count <= count - DUR_W'(1);
    end
  end

endmodule

// File: rtl/note_playback_sequencer.sv
// Melody playback sequencer: walks the note memory from address 0,
// presenting each note to the tone generator for its stored number of
// 32 Hz ticks, until an end marker or the last address.
//   clock, reset   : clock and async active-low reset
//   tick_32        : 32 Hz one-cycle tick
//   play, stop     : one-cycle start / abort requests
//   pause          : level, freezes counting and mutes output
//   loop           : level, restart from address 0 at end of song
//   mem            : note memory read bus (master side)
//   note_code      : current note, note_on : audible note present
//   busy           : not idle, done : one-cycle end-of-song pulse
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for play
// ST_FETCH | address presented, waiting for memory latency
// ST_LOAD  | entry valid on mem_data, decode it
// ST_PLAY  | sounding note, counting ticks
// ST_DONE  | song finished, done pulse
module note_playback_sequencer
  import music_box_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W  = DUR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick_32,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  note_playback_sequencer_if.master mem,
  output logic [NOTE_W-1:0] note_code,
  output logic              note_on,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  seq_state_e        state;
  logic [ADDR_W-1:0] addr;
  logic [NOTE_W-1:0] mem_note;
  logic [DUR_W-1:0]  mem_dur;
  logic              cnt_en;
  logic              cnt_load;
  logic              last_tick;
  logic              cur_audible;

  assign mem.mem_addr = addr;
  assign mem_note     = mem.mem_data[NOTE_W+DUR_W-1 -: NOTE_W];
  assign mem_dur      = mem.mem_data[DUR_W-1:0];

  assign cnt_en   = (state == ST_PLAY) && !pause;
  assign cnt_load = (state == ST_LOAD) && (mem_dur != DUR_W'(DUR_END)) && !stop;

  // The held note stays audible across FETCH/LOAD so equal consecutive
  // notes play without a gap.
  assign cur_audible = (note_code != NOTE_W'(NOTE_REST)) && !pause;

  note_duration_counter #(.DUR_W(DUR_W)) u_dur_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (mem_dur),
    .tick     (tick_32),
    .en       (cnt_en),
    .last_tick(last_tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      note_code <= '0;
      note_on   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= ST_IDLE;
        addr      <= '0;
        note_code <= '0;
        note_on   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            note_on <= 1'b0;
            if (play) begin
              addr  <= '0;
              busy  <= 1'b1;
              state <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            note_on <= cur_audible;
            state   <= ST_LOAD;
          end
          ST_LOAD: begin
            if (mem_dur == DUR_W'(DUR_END)) begin
              if (loop) begin
                addr    <= '0;
                note_on <= cur_audible;
                state   <= ST_FETCH;
              end else begin
                note_code <= '0;
                note_on   <= 1'b0;
                done      <= 1'b1;
                state     <= ST_DONE;
              end
            end else begin
              note_code <= mem_note;
              note_on   <= (mem_note != NOTE_W'(NOTE_REST)) && !pause;
              state     <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            note_on <= cur_audible;
            if (last_tick) begin
              // The last address ends the song rather than wrapping.
              if (addr == LAST_ADDR) begin
                if (loop) begin
                  addr  <= '0;
                  state <= ST_FETCH;
                end else begin
                  note_code <= '0;
                  note_on   <= 1'b0;
                  done      <= 1'b1;
                  state     <= ST_DONE;
                end
              end else begin
                addr  <= addr + ADDR_W'(1);
                state <= ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            note_on <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_playback_sequencer.sv
module tb_note_playback_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_32 = 1'b0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       loop = 1'b0;
  logic [3:0] note_code;
  logic       note_on, busy, done;

  logic [9:0] mem [32];
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;

  note_playback_sequencer_if #(.ADDR_W(5), .NOTE_W(4), .DUR_W(6)) bus ();

  note_playback_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .tick_32  (tick_32),
    .play     (play),
    .stop     (stop),
    .pause    (pause),
    .loop     (loop),
    .mem      (bus),
    .note_code(note_code),
    .note_on  (note_on),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  // synchronous 1-cycle note memory
  always @(posedge clock) bus.mem_data <= mem[bus.mem_addr];

  always @(posedge clock) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic       pause;
    logic       tick;
    logic [3:0] note;
    logic       on;
    logic       busy;
  } vec_t;

  vec_t tbl [7];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 10'd0;
  endtask

  task automatic do_tick(input int gap);
    tick_32 = 1'b1;
    step();
    tick_32 = 1'b0;
    repeat (gap - 1) step();
  endtask

  // Reference: expand the stored song into the note heard on each tick,
  // stopping at the end marker or after the last address.
  task automatic run_song(input int gap, input string tag);
    logic [3:0] exp_q[$];
    logic [9:0] e;
    int a;
    int d0;
    a = 0;
    forever begin
      e = mem[a];
      if (e[5:0] == 6'd0) break;
      repeat (int'(e[5:0])) exp_q.push_back(e[9:6]);
      if (a == 31) break;
      a++;
    end
    d0 = done_cnt;
    play = 1'b1; step(); play = 1'b0;
    repeat (4) step();
    foreach (exp_q[k]) begin
      chk({tag, " note"}, note_code, exp_q[k]);
      chk({tag, " on"}, note_on, exp_q[k] != 4'd0);
      chk({tag, " busy"}, busy, 1);
      do_tick(gap);
    end
    repeat (4) step();
    chk({tag, " done_count"}, done_cnt - d0, 1);
    chk({tag, " end_busy"}, busy, 0);
    chk({tag, " end_note"}, note_code, 0);
    chk({tag, " end_on"}, note_on, 0);
  endtask

  initial begin
    int d0;
    tbl[0] = '{pause: 1'b0, tick: 1'b1, note: 4'd5, on: 1'b1, busy: 1'b1};
    tbl[1] = '{pause: 1'b0, tick: 1'b1, note: 4'd5, on: 1'b1, busy: 1'b1};
    tbl[2] = '{pause: 1'b0, tick: 1'b1, note: 4'd7, on: 1'b1, busy: 1'b1};
    tbl[3] = '{pause: 1'b1, tick: 1'b1, note: 4'd7, on: 1'b0, busy: 1'b1};
    tbl[4] = '{pause: 1'b1, tick: 1'b1, note: 4'd7, on: 1'b0, busy: 1'b1};
    tbl[5] = '{pause: 1'b0, tick: 1'b1, note: 4'd7, on: 1'b1, busy: 1'b1};
    tbl[6] = '{pause: 1'b0, tick: 1'b1, note: 4'd0, on: 1'b0, busy: 1'b0};

    clear_mem();
    repeat (3) step();
    chk("rst note", note_code, 0);
    chk("rst on", note_on, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst addr", bus.mem_addr, 0);
    @(negedge clock) reset = 1'b1;
    step();

    // basic song with a pause inside note 7, table driven
    mem[0] = {4'd5, 6'd3}; mem[1] = {4'd7, 6'd2}; mem[2] = {4'd0, 6'd0};
    d0 = done_cnt;
    play = 1'b1; step(); play = 1'b0;
    repeat (4) step();
    chk("t1 start note", note_code, 5);
    chk("t1 start on", note_on, 1);
    for (int i = 0; i < 7; i++) begin
      pause = tbl[i].pause;
      tick_32 = tbl[i].tick;
      step();
      tick_32 = 1'b0;
      repeat (5) step();
      chk($sformatf("t1 row%0d note", i), note_code, tbl[i].note);
      chk($sformatf("t1 row%0d on", i), note_on, tbl[i].on);
      chk($sformatf("t1 row%0d busy", i), busy, tbl[i].busy);
    end
    pause = 1'b0;
    chk("t1 done_count", done_cnt - d0, 1);

    // loop: marker sends address back to 0, no done
    loop = 1'b1;
    d0 = done_cnt;
    play = 1'b1; step(); play = 1'b0;
    repeat (4) step();
    repeat (3) do_tick(6);
    chk("loop note7", note_code, 7);
    chk("loop addr1", bus.mem_addr, 1);
    repeat (2) do_tick(6);
    chk("loop wrap addr", bus.mem_addr, 0);
    chk("loop wrap note", note_code, 5);
    chk("loop wrap busy", busy, 1);
    repeat (3) do_tick(6);
    chk("loop again note7", note_code, 7);
    chk("loop no done", done_cnt - d0, 0);
    stop = 1'b1; step(); stop = 1'b0;
    loop = 1'b0;
    chk("loop stop busy", busy, 0);

    // rest entry between notes
    mem[0] = {4'd5, 6'd1}; mem[1] = {4'd0, 6'd4};
    mem[2] = {4'd7, 6'd1}; mem[3] = {4'd0, 6'd0};
    run_song(5, "rest");

    // pause for 5 ticks in a 3-tick note
    clear_mem();
    mem[0] = {4'd5, 6'd3};
    d0 = done_cnt;
    play = 1'b1; step(); play = 1'b0;
    repeat (4) step();
    do_tick(5);
    pause = 1'b1;
    repeat (5) do_tick(5);
    chk("pause on", note_on, 0);
    chk("pause note", note_code, 5);
    chk("pause busy", busy, 1);
    pause = 1'b0;
    repeat (2) step();
    chk("unpause on", note_on, 1);
    do_tick(5);
    chk("unpause remain note", note_code, 5);
    chk("unpause remain busy", busy, 1);
    do_tick(5);
    repeat (3) step();
    chk("pause done_count", done_cnt - d0, 1);
    chk("pause end busy", busy, 0);

    // play while busy is ignored; stop on the last tick wins
    mem[0] = {4'd5, 6'd2}; mem[1] = {4'd7, 6'd1}; mem[2] = {4'd0, 6'd0};
    d0 = done_cnt;
    play = 1'b1; step(); play = 1'b0;
    repeat (4) step();
    do_tick(5);
    play = 1'b1; step(); play = 1'b0;
    repeat (4) step();
    do_tick(5);
    chk("replay ignored note", note_code, 7);
    chk("replay ignored addr", bus.mem_addr, 1);
    tick_32 = 1'b1; stop = 1'b1;
    step();
    tick_32 = 1'b0; stop = 1'b0;
    chk("stop busy", busy, 0);
    chk("stop addr", bus.mem_addr, 0);
    chk("stop on", note_on, 0);
    chk("stop note", note_code, 0);
    repeat (6) step();
    chk("stop no done", done_cnt - d0, 0);
    run_song(5, "after_stop");

    // async reset mid-note, then a full 32-entry song with no marker
    for (int i = 0; i < 32; i++)
      mem[i] = {4'($urandom_range(1, 15)), 6'($urandom_range(1, 2))};
    mem[0] = {4'd9, 6'd3};
    play = 1'b1; step(); play = 1'b0;
    repeat (4) step();
    do_tick(3);
    #3 reset = 1'b0;
    #1;
    chk("arst note", note_code, 0);
    chk("arst on", note_on, 0);
    chk("arst busy", busy, 0);
    chk("arst addr", bus.mem_addr, 0);
    repeat (2) step();
    @(negedge clock) reset = 1'b1;
    step();
    run_song(5, "full32");

    // randomized songs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 7) == 0)
          mem[i] = {4'($urandom_range(0, 15)), 6'd0};
        else
          mem[i] = {4'($urandom_range(0, 15)), 6'($urandom_range(1, 3))};
      end
      run_song(int'($urandom_range(4, 8)), $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
